multicycle_control_unit: RTL and testbench

Multi-cycle RV32I control FSM: the successor to the single-cycle CPU's combinational control unit. It sequences each instruction through IF/ID/EX/MEM/WB over a shared, variable-latency memory port. It drives the datapath muxes and write enables, and it halts on `ecall` or on a fault. It sits in the CPU top, between the instruction register (IR) fields and the datapath. It also keeps cycle and retired-instruction counters.

---
 rtl/mc_pkg.sv | 45 ++++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/multicycle_control_unit.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state, opcode and select encodings shared by the multi-cycle control unit
package mc_pkg;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] SRC_B_REG = 2'b00;
    localparam logic [1:0] SRC_B_IMM = 2'b01;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNC   = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MDR = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b10;

    function automatic logic is_valid_opcode(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts memory wait cycles and flags the cycle that reaches the limit
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [W-1:0] LIMIT = W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (count_en)
            count <= count + W'(1);
    end

    // Fires in the cycle whose increment would reach MEM_TIMEOUT, so a ready in that cycle still wins.
    assign expired = (MEM_TIMEOUT != 0) && count_en && (count == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I control FSM with timeout fault and perf counters
module multicycle_control_unit
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             halt_req,
    input  logic             mem_ready,
    input  logic             alu_bcond,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_class,
    output logic [1:0]       pc_source,
    output logic [1:0]       wb_sel,
    output logic             is_halted,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    state_t     state;
    logic [1:0] cause;
    logic       in_mem_state, wait_clear, wait_en, expired, is_store, is_load;

    assign in_mem_state = (state == S_IF) || (state == S_MEM);
    assign wait_clear   = !in_mem_state || mem_ready;
    assign wait_en      = in_mem_state && !mem_ready;
    assign is_store     = (opcode == OP_STORE);
    assign is_load      = (opcode == OP_LOAD);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (wait_clear),
        .count_en (wait_en),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IF;
            cause <= FAULT_NONE;
        end else begin
            case (state)
                S_IF:
                    if (mem_ready) state <= S_ID;
                    else if (expired) begin
                        state <= S_HALT;
                        cause <= FAULT_TIMEOUT;
                    end
                S_ID:
                    if (opcode == OP_SYSTEM) state <= halt_req ? S_HALT : S_IF;
                    else if (!is_valid_opcode(opcode)) begin
                        state <= S_HALT;
                        cause <= FAULT_ILLEGAL;
                    end else state <= S_EX;
                S_EX:
                    case (opcode)
                        OP_LOAD, OP_STORE:                    state <= S_MEM;
                        OP_BRANCH, OP_JAL, OP_JALR, OP_FENCE: state <= S_IF;
                        default:                              state <= S_WB;
                    endcase
                S_MEM:
                    if (mem_ready) state <= is_store ? S_IF : S_WB;
                    else if (expired) begin
                        state <= S_HALT;
                        cause <= FAULT_TIMEOUT;
                    end
                S_WB:    state <= S_IF;
                default: state <= S_HALT;
            endcase
        end
    end

    // Everything is forced low while reset is held, even though the state already reads IF.
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRC_B_REG;
        alu_class = ALU_ADD;
        pc_source = PC_PLUS4;
        wb_sel    = WB_ALU;
        if (reset) begin
            case (state)
                S_IF: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                S_ID: begin
                    alu_src_b = SRC_B_IMM;
                    pc_write  = (opcode == OP_SYSTEM) && !halt_req;
                end
                S_EX:
                    case (opcode)
                        OP_REG: begin
                            alu_src_a = 1'b1;
                            alu_class = ALU_FUNC;
                        end
                        OP_IMM: begin
                            alu_src_a = 1'b1;
                            alu_src_b = SRC_B_IMM;
                            alu_class = ALU_FUNC;
                        end
                        OP_LOAD, OP_STORE, OP_LUI: begin
                            alu_src_a = 1'b1;
                            alu_src_b = SRC_B_IMM;
                        end
                        OP_AUIPC: alu_src_b = SRC_B_IMM;
                        OP_BRANCH: begin
                            alu_src_a = 1'b1;
                            alu_class = ALU_BRANCH;
                            pc_write  = 1'b1;
                            pc_source = alu_bcond ? PC_ALUOUT : PC_PLUS4;
                        end
                        OP_JAL: begin
                            pc_write  = 1'b1;
                            pc_source = PC_ALUOUT;
                            reg_write = 1'b1;
                            wb_sel    = WB_PC4;
                        end
                        OP_JALR: begin
                            alu_src_a = 1'b1;
                            alu_src_b = SRC_B_IMM;
                            pc_write  = 1'b1;
                            pc_source = PC_ALU;
                            reg_write = 1'b1;
                            wb_sel    = WB_PC4;
                        end
                        // FENCE is a no-op on this single-port core: just step the PC.
                        OP_FENCE: pc_write = 1'b1;
                        default: ;
                    endcase
                S_MEM: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    mem_we   = is_store;
                    pc_write = is_store && mem_ready;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = is_load ? WB_MDR : WB_ALU;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else if (state != S_HALT) begin
            cycle_count <= cycle_count + CNT_W'(1);
            if (pc_write) instret_count <= instret_count + CNT_W'(1);
        end
    end

    assign is_halted   = (state == S_HALT);
    assign fault       = (cause != FAULT_NONE);
    assign fault_cause = cause;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized instruction-level bench for multicycle_control_unit
module tb_multicycle_control_unit;

    localparam logic [6:0] T_LUI = 7'h37, T_AUIPC = 7'h17, T_JAL = 7'h6F, T_JALR = 7'h67;
    localparam logic [6:0] T_BR = 7'h63, T_LOAD = 7'h03, T_STORE = 7'h23, T_IMM = 7'h13;
    localparam logic [6:0] T_REG = 7'h33, T_SYS = 7'h73;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  opcode = T_REG;
    logic        halt_req = 1'b0, mem_ready = 1'b0, alu_bcond = 1'b0;
    logic        pc_write, ir_write, iord, mem_req, mem_we, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_class, pc_source, wb_sel, fault_cause;
    logic        is_halted, fault;
    logic [31:0] cycle_count, instret_count;

    int checks = 0, failures = 0;
    int unsigned m_instret = 0, m_cycles = 0;

    multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .halt_req(halt_req),
        .mem_ready(mem_ready), .alu_bcond(alu_bcond), .pc_write(pc_write),
        .ir_write(ir_write), .iord(iord), .mem_req(mem_req), .mem_we(mem_we),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_class(alu_class), .pc_source(pc_source), .wb_sel(wb_sel),
        .is_halted(is_halted), .fault(fault), .fault_cause(fault_cause),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; mem_ready = 1'b1; opcode = T_REG; halt_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_strobes", {mem_req, pc_write, ir_write, reg_write, mem_we}, 0);
        check_eq("rst_halt_fault", {is_halted, fault, fault_cause}, 0);
        check_eq("rst_counters", cycle_count | instret_count, 0);
        @(negedge clk);
        reset = 1'b1;
        m_instret = 0; m_cycles = 0;
    endtask

    // Runs one instruction with wif/wmem wait states, checking it against spec-level rules.
    task automatic run_instr(input logic [6:0] op, input logic hreq, input logic bc,
                             input int wif, input int wmem);
        int n = 0, wcur = 0, i_ir = -1, lat;
        int mreq_n = 0, iord_n = 0, we_n = 0, we_bad = 0, rw_n = 0, pw_n = 0, ir_n = 0;
        logic [1:0] wb_seen = 0, ps_seen = 0, cls_ex = 0, srcb_id = 0;
        logic srca_id = 1'b1, done = 1'b0, halted = 1'b0, pw;
        logic memop, writes;
        logic [1:0] exp_wb, exp_ps, exp_cls;
        opcode = op; halt_req = hreq; alu_bcond = bc;
        while (!done && n < 60) begin
            if (mem_req) begin
                if (wcur == (iord ? wmem : wif)) begin mem_ready = 1'b1; wcur = 0; end
                else begin mem_ready = 1'b0; wcur++; end
            end else mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (is_halted) begin
                halted = 1'b1; done = 1'b1;
            end else begin
                mreq_n += int'(mem_req);
                iord_n += int'(mem_req && iord);
                we_n   += int'(mem_we);
                we_bad += int'(mem_we && !mem_req);
                if (reg_write) begin rw_n++; wb_seen = wb_sel; end
                if (ir_write) begin ir_n++; i_ir = n; end
                if (i_ir >= 0 && n == i_ir + 1) begin srca_id = alu_src_a; srcb_id = alu_src_b; end
                if (i_ir >= 0 && n == i_ir + 2) cls_ex = alu_class;
                pw = pc_write;
                if (pw) begin pw_n++; ps_seen = pc_source; end
                n++;
                @(negedge clk);
                if (pw) done = 1'b1;
            end
        end
        if (op == T_SYS && hreq) begin
            m_cycles += 2 + wif;
            check_eq("ecall_halted", halted, 1);
            check_eq("ecall_fault", {fault, fault_cause}, 0);
            check_eq("ecall_lat", n, 2 + wif);
            check_eq("ecall_instret", instret_count, m_instret);
            check_eq("ecall_cycles", cycle_count, m_cycles);
            return;
        end
        memop  = (op == T_LOAD) || (op == T_STORE);
        writes = (op == T_REG) || (op == T_IMM) || (op == T_LOAD) || (op == T_LUI) ||
                 (op == T_AUIPC) || (op == T_JAL) || (op == T_JALR);
        case (op)
            T_BR, T_JAL, T_JALR: lat = 3;
            T_LOAD:              lat = 5;
            T_SYS:               lat = 2;
            default:             lat = 4;
        endcase
        lat += wif + (memop ? wmem : 0);
        exp_wb  = (op == T_LOAD) ? 2'd1 : (op == T_JAL || op == T_JALR) ? 2'd2 : 2'd0;
        exp_ps  = (op == T_BR) ? {1'b0, bc} : (op == T_JAL) ? 2'd1 : (op == T_JALR) ? 2'd2 : 2'd0;
        exp_cls = (op == T_REG || op == T_IMM) ? 2'd2 : (op == T_BR) ? 2'd1 : 2'd0;
        m_instret++;
        m_cycles += lat;
        check_eq("latency", n, lat);
        check_eq("not_halted", halted, 0);
        check_eq("mem_req_cycles", mreq_n, (wif + 1) + (memop ? wmem + 1 : 0));
        check_eq("iord_cycles", iord_n, memop ? wmem + 1 : 0);
        check_eq("mem_we_cycles", we_n, (op == T_STORE) ? wmem + 1 : 0);
        check_eq("we_without_req", we_bad, 0);
        check_eq("ir_write_count", ir_n, 1);
        check_eq("pc_write_count", pw_n, 1);
        check_eq("pc_source", ps_seen, exp_ps);
        check_eq("reg_write_count", rw_n, writes ? 1 : 0);
        if (writes) check_eq("wb_sel", wb_seen, exp_wb);
        check_eq("id_alu_src", {srca_id, srcb_id}, 3'b001);
        if (op != T_SYS) check_eq("ex_alu_class", cls_ex, exp_cls);
        check_eq("instret", instret_count, m_instret);
        check_eq("cycles", cycle_count, m_cycles);
    endtask

    logic [6:0] ops [10] = '{T_REG, T_IMM, T_LOAD, T_STORE, T_LUI, T_AUIPC, T_BR, T_JAL, T_JALR, T_SYS};

    initial begin
        logic [6:0] op;
        do_reset();
        #1 check_eq("first_mem_req", {mem_req, iord}, 2'b10);

        run_instr(T_REG, 1'b0, 1'b0, 0, 0);
        check_eq("add_instret_1", instret_count, 1);
        run_instr(T_LOAD, 1'b0, 1'b0, 0, 3);
        run_instr(T_BR, 1'b0, 1'b1, 0, 0);
        run_instr(T_BR, 1'b0, 1'b0, 0, 0);
        run_instr(T_SYS, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 50; i++) begin
            op = ops[$urandom_range(0, 9)];
            run_instr(op, (op == T_SYS) ? 1'b0 : 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        run_instr(T_SYS, 1'b1, 1'b0, 1, 0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("halt_cycle_freeze", cycle_count, m_cycles);
        check_eq("halt_no_strobes", {mem_req, pc_write, ir_write, is_halted}, 4'b0001);

        // Memory stuck in IF: the 4th waiting cycle expires.
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check_eq("timeout_waiting", is_halted, 0);
            @(negedge clk);
        end
        #1;
        check_eq("timeout_halt", {is_halted, fault, fault_cause}, 4'b1101);
        check_eq("timeout_cycles", cycle_count, 4);

        // Ready arriving on the limit cycle wins.
        do_reset();
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        mem_ready = 1'b1;
        #1 check_eq("late_ready_ir_write", ir_write, 1);
        @(negedge clk);
        #1 check_eq("late_ready_no_fault", {is_halted, fault, alu_src_b}, 4'b0001);

        do_reset();
        opcode = 7'h7F;
        repeat (2) @(negedge clk);
        #1;
        check_eq("illegal_halt", {is_halted, fault, fault_cause}, 4'b1110);
        check_eq("illegal_instret", instret_count, 0);

        // Reset during the MEM phase of a store.
        do_reset();
        opcode = T_STORE;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1 check_eq("store_in_mem", {mem_req, iord, mem_we}, 3'b111);
        @(negedge clk);
        #2 reset = 1'b0;
        mem_ready = 1'b1;
        #1 check_eq("rst_mid_strobes", {pc_write, mem_req, mem_we}, 0);
        @(negedge clk);
        #1;
        check_eq("rst_mid_counters", cycle_count | instret_count, 0);
        check_eq("rst_mid_pc_write", pc_write, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 check_eq("rst_mid_restart", {mem_req, iord, mem_we}, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
